// File: rtl/dmi_jtag_tap_mc.sv
// Multi-channel JTAG TAP for debug transport: 16-state controller, IR, BYPASS/IDCODE/DTMCS
// and NumCh external DR channels (channel 0 is the DMI).
module dmi_jtag_tap_mc #(
   parameter int unsigned IrLength    = 5,
   parameter logic [31:0] IdcodeValue = 32'h00000001,
   parameter int unsigned NumCh       = 1,
   parameter int unsigned IdcodeIr    = 'h01,
   parameter int unsigned DtmcsIr     = 'h10,
   parameter int unsigned ChIrBase    = 'h11,
   parameter int unsigned Abits       = 7,
   parameter int unsigned IdleHint    = 1
) (
   input  logic             tck_i,
   input  logic             trst_i,
   input  logic             tms_i,
   input  logic             td_i,
   output logic             td_o,
   output logic             tdo_oe_o,
   output logic [3:0]       tap_state_o,
   output logic             test_logic_reset_o,
   output logic             capture_dr_o,
   output logic             shift_dr_o,
   output logic             update_dr_o,
   output logic             dr_tdi_o,
   output logic [NumCh-1:0] ch_select_o,
   input  logic [NumCh-1:0] ch_tdo_i,
   input  logic [1:0]       dmi_error_i,
   output logic             dmi_reset_o,
   output logic             dmi_hardreset_o
);

   typedef enum logic [3:0] {
      test_logic_reset = 4'd0,  run_test_idle = 4'd1,  select_dr_scan = 4'd2,
      capture_dr       = 4'd3,  shift_dr      = 4'd4,  exit1_dr       = 4'd5,
      pause_dr         = 4'd6,  exit2_dr      = 4'd7,  update_dr      = 4'd8,
      select_ir_scan   = 4'd9,  capture_ir    = 4'd10, shift_ir       = 4'd11,
      exit1_ir         = 4'd12, pause_ir      = 4'd13, exit2_ir       = 4'd14,
      update_ir        = 4'd15
   } tap_state_e;

   localparam logic [IrLength-1:0] code_idcode = IrLength'(IdcodeIr);
   localparam logic [IrLength-1:0] code_dtmcs  = IrLength'(DtmcsIr);

   // Index 0 = IDCODE, 1 = DTMCS, 2.. = channels.
   function automatic logic [IrLength-1:0] code_at(input int unsigned k);
      if (k == 0) return IrLength'(IdcodeIr);
      if (k == 1) return IrLength'(DtmcsIr);
      return IrLength'(ChIrBase + k - 2);
   endfunction

   function automatic bit codes_ok();
      for (int unsigned a = 0; a < NumCh + 2; a++) begin
         if (code_at(a) == '0 || code_at(a) == '1) return 1'b0;
         for (int unsigned b = 0; b < a; b++)
            if (code_at(a) == code_at(b)) return 1'b0;
      end
      return 1'b1;
   endfunction

   localparam bit codes_valid = codes_ok();

   if (IrLength < 2) begin : g_chk_irlen
      $error("IrLength must be >= 2");
   end
   if (NumCh < 1 || NumCh > 8) begin : g_chk_numch
      $error("NumCh must be 1..8");
   end
   if (!IdcodeValue[0]) begin : g_chk_idcode
      $error("IdcodeValue bit 0 must be 1");
   end
   if (!codes_valid) begin : g_chk_codes
      $error("IR codes collide or are all-zeros/all-ones");
   end

   tap_state_e          state, next;
   logic [IrLength-1:0] ir, ir_shift;
   logic                bypass;
   logic [31:0]         idcode, dtmcs;
   logic                sel_idcode, sel_dtmcs;
   logic [NumCh-1:0]    ch_sel;
   logic                tdo_mux;
   logic                dmi_reset, dmi_hardreset;

   always_comb begin
      next = test_logic_reset;
      case (state)
         test_logic_reset: next = tms_i ? test_logic_reset : run_test_idle;
         run_test_idle:    next = tms_i ? select_dr_scan   : run_test_idle;
         select_dr_scan:   next = tms_i ? select_ir_scan   : capture_dr;
         capture_dr:       next = tms_i ? exit1_dr         : shift_dr;
         shift_dr:         next = tms_i ? exit1_dr         : shift_dr;
         exit1_dr:         next = tms_i ? update_dr        : pause_dr;
         pause_dr:         next = tms_i ? exit2_dr         : pause_dr;
         exit2_dr:         next = tms_i ? update_dr        : shift_dr;
         update_dr:        next = tms_i ? select_dr_scan   : run_test_idle;
         select_ir_scan:   next = tms_i ? test_logic_reset : capture_ir;
         capture_ir:       next = tms_i ? exit1_ir         : shift_ir;
         shift_ir:         next = tms_i ? exit1_ir         : shift_ir;
         exit1_ir:         next = tms_i ? update_ir        : pause_ir;
         pause_ir:         next = tms_i ? exit2_ir         : pause_ir;
         exit2_ir:         next = tms_i ? update_ir        : shift_ir;
         update_ir:        next = tms_i ? select_dr_scan   : run_test_idle;
         default:          next = test_logic_reset;
      endcase
   end

   assign sel_idcode = (ir == code_idcode);
   assign sel_dtmcs  = (ir == code_dtmcs);
   for (genvar i = 0; i < NumCh; i++) begin : g_ch
      assign ch_sel[i] = (ir == IrLength'(ChIrBase + i));
   end

   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         state         <= test_logic_reset;
         ir            <= code_idcode;
         ir_shift      <= '0;
         bypass        <= 1'b0;
         idcode        <= IdcodeValue;
         dtmcs         <= '0;
         dmi_reset     <= 1'b0;
         dmi_hardreset <= 1'b0;
      end else begin
         state <= next;
         // Pulses are registered so they land in the cycle after UpdateDr.
         dmi_reset     <= (state == update_dr) && sel_dtmcs && dtmcs[16];
         dmi_hardreset <= (state == update_dr) && sel_dtmcs && dtmcs[17];
         case (state)
            test_logic_reset: begin
               ir       <= code_idcode;
               ir_shift <= '0;
               bypass   <= 1'b0;
            end
            capture_ir: ir_shift <= IrLength'(1);
            shift_ir:   ir_shift <= {td_i, ir_shift[IrLength-1:1]};
            update_ir:  ir       <= ir_shift;
            capture_dr: begin
               if (sel_idcode) idcode <= IdcodeValue;
               else if (sel_dtmcs)
                  dtmcs <= {17'b0, 3'(IdleHint), dmi_error_i, 6'(Abits), 4'd1};
               else if (ch_sel == '0) bypass <= 1'b0;
            end
            shift_dr: begin
               if (sel_idcode) idcode <= {td_i, idcode[31:1]};
               else if (sel_dtmcs) dtmcs <= {td_i, dtmcs[31:1]};
               else if (ch_sel == '0) bypass <= td_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      tdo_mux = bypass;
      if (state == shift_ir) tdo_mux = ir_shift[0];
      else if (sel_idcode)   tdo_mux = idcode[0];
      else if (sel_dtmcs)    tdo_mux = dtmcs[0];
      else
         for (int i = 0; i < NumCh; i++)
            if (ch_sel[i]) tdo_mux = ch_tdo_i[i];
   end

   always_ff @(negedge tck_i) begin
      if (trst_i) begin
         td_o     <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else begin
         td_o     <= tdo_mux;
         tdo_oe_o <= (state == shift_ir) || (state == shift_dr);
      end
   end

   assign tap_state_o        = state;
   assign test_logic_reset_o = (state == test_logic_reset);
   assign capture_dr_o       = (state == capture_dr);
   assign shift_dr_o         = (state == shift_dr);
   assign update_dr_o        = (state == update_dr);
   assign dr_tdi_o           = td_i;
   assign ch_select_o        = ch_sel;
   assign dmi_reset_o        = dmi_reset;
   assign dmi_hardreset_o    = dmi_hardreset;

endmodule

// File: tb/tb_dmi_jtag_tap_mc.sv
// Randomized bench for dmi_jtag_tap_mc with NumCh=3, checked against a table-driven TAP model
// and register values computed from the DTM field layout.
module tb_dmi_jtag_tap_mc;

   localparam int NCH = 3;
   localparam logic [31:0] IDV = 32'h00000001;

   logic           tck = 1'b0, trst = 1'b0, tms = 1'b0, tdi = 1'b0;
   logic           tdo, tdo_oe, tlr, cap_dr, sh_dr, upd_dr, dr_tdi, dmi_rst, dmi_hrst;
   logic [3:0]     tap_state;
   logic [NCH-1:0] ch_sel, ch_tdo = '0;
   logic [1:0]     dmi_err = 2'd0;

   int checks = 0, failures = 0;
   int mstate = 0;
   // Next-state tables of the IEEE 1149.1 controller, indexed by state code.
   int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
   logic [NCH-1:0] ch_log [64];

   dmi_jtag_tap_mc #(.NumCh(NCH)) dut (
      .tck_i(tck), .trst_i(trst), .tms_i(tms), .td_i(tdi), .td_o(tdo), .tdo_oe_o(tdo_oe),
      .tap_state_o(tap_state), .test_logic_reset_o(tlr), .capture_dr_o(cap_dr),
      .shift_dr_o(sh_dr), .update_dr_o(upd_dr), .dr_tdi_o(dr_tdi), .ch_select_o(ch_sel),
      .ch_tdo_i(ch_tdo), .dmi_error_i(dmi_err), .dmi_reset_o(dmi_rst),
      .dmi_hardreset_o(dmi_hrst)
   );

   always #5 tck = ~tck;

   function automatic logic [31:0] dtmcs_exp(input logic [1:0] err);
      return (32'd1 << 12) + (32'(err) << 10) + (32'd7 << 4) + 32'd1;
   endfunction

   task automatic tick(input logic t, input logic d);
      tms = t; tdi = d;
      @(posedge tck); @(negedge tck); #1;
      if (trst) mstate = 0; else mstate = t ? nxt1[mstate] : nxt0[mstate];
   endtask

   task automatic scan_ir(input logic [4:0] code, output logic [4:0] cap);
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 5; i++) begin
         cap[i] = tdo;
         tick(i == 4, code[i]);
      end
      tick(1, 0); tick(0, 0);
   endtask

   task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                          output logic rst_p, output logic hrst_p, output logic stray,
                          output logic oe_bad);
      dout = '0; oe_bad = 1'b0;
      tick(1, 0); tick(0, 0);
      ch_tdo = NCH'($urandom); ch_log[0] = ch_tdo;
      tick(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo;
         if (tdo_oe !== 1'b1) oe_bad = 1'b1;
         ch_tdo = NCH'($urandom);
         if (i + 1 < n) ch_log[i+1] = ch_tdo;
         tick(i == n - 1, din[i]);
      end
      tick(1, 0);
      stray = dmi_rst | dmi_hrst;
      tick(0, 0);
      rst_p = dmi_rst; hrst_p = dmi_hrst;
      tick(0, 0);
      stray = stray | dmi_rst | dmi_hrst;
   endtask

   task automatic test_reset;
      trst = 1'b1; tick(1, 0);
      checks++; if (tap_state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", tap_state); end
      checks++; if ({tdo, tdo_oe} !== 2'b00) begin failures++; $display("FAIL reset_tdo got=%b exp=00", {tdo, tdo_oe}); end
      checks++; if ({tlr, cap_dr, sh_dr, upd_dr} !== 4'b1000) begin failures++; $display("FAIL reset_strobes got=%b exp=1000", {tlr, cap_dr, sh_dr, upd_dr}); end
      checks++; if ({dmi_rst, dmi_hrst, ch_sel} !== '0) begin failures++; $display("FAIL reset_pulses got=%b exp=0", {dmi_rst, dmi_hrst, ch_sel}); end
      trst = 1'b0; tick(0, 0);
      checks++; if (tap_state !== 4'(mstate)) begin failures++; $display("FAIL reset_to_rti got=%0d exp=%0d", tap_state, mstate); end
   endtask

   task automatic test_idcode;
      logic [63:0] din, dout; logic rp, hp, st, ob;
      din = {$urandom, $urandom};
      scan_dr(64, din, dout, rp, hp, st, ob);
      checks++; if (dout[31:0] !== IDV) begin failures++; $display("FAIL idcode_out got=%h exp=%h", dout[31:0], IDV); end
      checks++; if (dout[63:32] !== din[31:0]) begin failures++; $display("FAIL idcode_shift got=%h exp=%h", dout[63:32], din[31:0]); end
      checks++; if ({rp, hp, st, ob} !== 4'b0) begin failures++; $display("FAIL idcode_side got=%b exp=0000", {rp, hp, st, ob}); end
   endtask

   task automatic test_ir_capture;
      logic [4:0] cap;
      scan_ir(5'h10, cap);
      checks++; if (cap !== 5'b00001) begin failures++; $display("FAIL ir_capture got=%b exp=00001", cap); end
   endtask

   task automatic test_dtmcs;
      logic [63:0] din, dout; logic rp, hp, st, ob; logic [4:0] cap;
      logic [1:0] errs [3];
      errs[0] = 2'd0; errs[1] = 2'd2; errs[2] = 2'($urandom_range(0, 3));
      scan_ir(5'h10, cap);
      for (int k = 0; k < 3; k++) begin
         dmi_err = errs[k];
         din = {32'h0, $urandom & 32'hFFFC_FFFF};
         scan_dr(32, din, dout, rp, hp, st, ob);
         checks++; if (dout[31:0] !== dtmcs_exp(errs[k])) begin failures++; $display("FAIL dtmcs_capture got=%h exp=%h", dout[31:0], dtmcs_exp(errs[k])); end
         checks++; if ({rp, hp, st} !== 3'b0) begin failures++; $display("FAIL dtmcs_nopulse got=%b exp=000", {rp, hp, st}); end
      end
      dmi_err = 2'd0;
   endtask

   task automatic test_dmi_pulses;
      logic [63:0] din, dout; logic rp, hp, st, ob; logic [4:0] cap;
      logic [1:0] r;
      scan_ir(5'h10, cap);
      for (int k = 0; k < 6; k++) begin
         r = (k < 4) ? 2'(k) : 2'($urandom);
         din = {32'h0, $urandom};
         din[16] = r[0]; din[17] = r[1];
         scan_dr(32, din, dout, rp, hp, st, ob);
         checks++; if ({hp, rp} !== r) begin failures++; $display("FAIL dmi_pulse got=%b exp=%b", {hp, rp}, r); end
         checks++; if (st !== 1'b0) begin failures++; $display("FAIL dmi_pulse_width got=%b exp=0", st); end
      end
   endtask

   task automatic test_channels;
      logic [63:0] din, dout; logic rp, hp, st, ob; logic [4:0] cap;
      int bad;
      for (int c = NCH - 1; c >= 0; c--) begin
         scan_ir(5'(5'h11 + c), cap);
         checks++; if (ch_sel !== NCH'(1 << c)) begin failures++; $display("FAIL ch_select got=%b exp=%b", ch_sel, NCH'(1 << c)); end
         din = {$urandom, $urandom};
         scan_dr(24, din, dout, rp, hp, st, ob);
         bad = 0;
         for (int i = 0; i < 24; i++) if (dout[i] !== ch_log[i][c]) bad++;
         checks++; if (bad != 0 || ob) begin failures++; $display("FAIL ch_tdo ch=%0d got=%0d wrong bits oe_bad=%b exp=0", c, bad, ob); end
      end
   endtask

   task automatic test_bypass;
      logic [63:0] din, dout; logic rp, hp, st, ob; logic [4:0] cap, code;
      int bad;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) code = 5'h07;
         else if (k == 1) code = 5'h1F;
         else begin
            code = 5'($urandom_range(2, 15));
         end
         scan_ir(code, cap);
         checks++; if (ch_sel !== '0) begin failures++; $display("FAIL bypass_sel got=%b exp=0", ch_sel); end
         din = {$urandom, $urandom};
         scan_dr(32, din, dout, rp, hp, st, ob);
         bad = (dout[0] !== 1'b0) ? 1 : 0;
         for (int i = 1; i < 32; i++) if (dout[i] !== din[i-1]) bad++;
         checks++; if (bad != 0) begin failures++; $display("FAIL bypass_delay code=%h got=%0d wrong bits exp=0", code, bad); end
      end
   endtask

   task automatic test_tms_reset;
      logic [63:0] din, dout; logic rp, hp, st, ob; logic [4:0] cap;
      scan_ir(5'h12, cap);
      tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 5; i++) begin
         tick(1, 0);
         checks++; if ({tap_state, upd_dr} !== {4'(mstate), mstate == 8}) begin failures++; $display("FAIL tms5_walk got=%0d/%b exp=%0d", tap_state, upd_dr, mstate); end
      end
      checks++; if (tap_state !== 4'd0) begin failures++; $display("FAIL tms5_tlr got=%0d exp=0", tap_state); end
      tick(0, 0);
      din = {$urandom, $urandom};
      scan_dr(32, din, dout, rp, hp, st, ob);
      checks++; if (dout[31:0] !== IDV) begin failures++; $display("FAIL tms5_ir_idcode got=%h exp=%h", dout[31:0], IDV); end
   endtask

   task automatic test_reset_midscan;
      logic [4:0] cap; int bad;
      scan_ir(5'h10, cap);
      tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 20; i++) tick(0, 1);
      trst = 1'b1; tick(0, 1);
      checks++; if ({tap_state, tdo, tdo_oe} !== 6'b0) begin failures++; $display("FAIL midscan_reset got=%b exp=000000", {tap_state, tdo, tdo_oe}); end
      trst = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick(i == 3 ? 1'b0 : 1'b1, 0);
         if (dmi_rst | dmi_hrst | upd_dr) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL midscan_pulses got=%0d exp=0", bad); end
   endtask

   task automatic test_fsm_random;
      int bad;
      logic t;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         t = ($urandom_range(0, 99) < 40);
         tick(t, 1'($urandom));
         if (tap_state !== 4'(mstate)) bad++;
         if ({tlr, cap_dr, sh_dr, upd_dr} !== {mstate == 0, mstate == 3, mstate == 4, mstate == 8}) bad++;
         if (tdo_oe !== (mstate == 4 || mstate == 11)) bad++;
         if (dr_tdi !== tdi) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL fsm_random got=%0d wrong steps exp=0", bad); end
   endtask

   initial begin
      @(negedge tck); #1;
      test_reset;
      test_idcode;
      test_ir_capture;
      test_dtmcs;
      test_dmi_pulses;
      test_channels;
      test_bypass;
      test_tms_reset;
      test_reset_midscan;
      test_fsm_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
